// File: rtl/panel_ctrl_if.sv
// Front-panel signal bundle: raw buttons and counter feedback in, command pulses and run state out.
interface panel_ctrl_if;
    logic       btn_next;
    logic       btn_run;
    logic       btn_speedrun;
    logic       btn_halt;
    logic [7:0] count_in;
    logic       next_o;
    logic       run_o;
    logic       speedrun_o;
    logic       halt_o;
    logic [1:0] run_state;

    modport master (
        output btn_next, btn_run, btn_speedrun, btn_halt, count_in,
        input  next_o, run_o, speedrun_o, halt_o, run_state
    );

    modport slave (
        input  btn_next, btn_run, btn_speedrun, btn_halt, count_in,
        output next_o, run_o, speedrun_o, halt_o, run_state
    );
endinterface

// File: rtl/panel_ctrl.sv
// Front-panel run control: synchronise and debounce four buttons, arbitrate single-cycle
// commands (halt > next > run > speedrun), and track the counter's run state for the LEDs.
module panel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    panel_ctrl_if.slave  pif
);
    localparam int unsigned HALT  = 0;
    localparam int unsigned NEXT  = 1;
    localparam int unsigned RUN   = 2;
    localparam int unsigned SPEED = 3;
    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STOPPED  = 2'b00,
        RUN_SLOW = 2'b01,
        RUN_FAST = 2'b10,
        STEPPING = 2'b11
    } state_t;

    logic [3:0]  btn;
    logic [3:0]  s1, s2, db, db_d, pend, pend_next;
    logic [3:0]  grant, clr, pulse;
    logic [19:0] cnt [4];
    logic [7:0]  count_prev;
    logic        chg;
    state_t      state, state_next;

    assign btn = {pif.btn_speedrun, pif.btn_run, pif.btn_next, pif.btn_halt};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            db         <= '0;
            db_d       <= '0;
            pend       <= '0;
            pulse      <= '0;
            count_prev <= '0;
            chg        <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 20'd1;
                end
            end
            pend       <= pend_next;
            pulse      <= grant;
            count_prev <= pif.count_in;
            chg        <= (pif.count_in != count_prev);
        end
    end

    // Arbiter; a granted halt also drops any queued run/speedrun, but keeps a queued step.
    always_comb begin
        grant = '0;
        if (pend[HALT])       grant[HALT]  = 1'b1;
        else if (pend[NEXT])  grant[NEXT]  = 1'b1;
        else if (pend[RUN])   grant[RUN]   = 1'b1;
        else if (pend[SPEED]) grant[SPEED] = 1'b1;
        clr = grant;
        if (grant[HALT]) begin
            clr[RUN]   = 1'b1;
            clr[SPEED] = 1'b1;
        end
        pend_next = (pend | (db & ~db_d)) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= STOPPED;
        else     state <= state_next;
    end

    // Issued commands override a count change seen in the same cycle.
    always_comb begin
        state_next = state;
        if (grant[HALT])                   state_next = STOPPED;
        else if (grant[NEXT])              state_next = STEPPING;
        else if (grant[RUN])               state_next = RUN_SLOW;
        else if (grant[SPEED])             state_next = RUN_FAST;
        else if (state == STEPPING && chg) state_next = STOPPED;
    end

    assign pif.halt_o     = pulse[HALT];
    assign pif.next_o     = pulse[NEXT];
    assign pif.run_o      = pulse[RUN];
    assign pif.speedrun_o = pulse[SPEED];
    assign pif.run_state  = state;
endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl with a short debounce: expected commands are queued when a
// press is driven and checked (code and arrival edge) when a pulse appears.
module tb_panel_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned LAT = DB + 4;

    localparam logic [3:0] C_HALT  = 4'b0001;
    localparam logic [3:0] C_NEXT  = 4'b0010;
    localparam logic [3:0] C_RUN   = 4'b0100;
    localparam logic [3:0] C_SPEED = 4'b1000;

    typedef struct {
        logic [3:0]  code;
        int unsigned at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    exp_t        exp_q[$];

    panel_ctrl_if pif();

    panel_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] pulses();
        return {pif.speedrun_o, pif.run_o, pif.next_o, pif.halt_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] code, input int unsigned at);
        exp_t e;
        e.code = code;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_cmd(input string tag);
        exp_t e;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (pulses() != 4'b0000) seen = 1'b1;
        end
        e = exp_q.pop_front();
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_code"}, 32'(pulses()), 32'(e.code));
            chk({tag, "_cycle"}, cyc, e.at);
        end
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 32'(pulses()), 32'd0);
        end
    endtask

    initial begin
        int unsigned c;
        pif.btn_next     = 1'b0;
        pif.btn_run      = 1'b0;
        pif.btn_speedrun = 1'b0;
        pif.btn_halt     = 1'b0;
        pif.count_in     = 8'h05;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pulses", 32'(pulses()), 32'd0);
        chk("reset_state", 32'(pif.run_state), 32'd0);
        quiet("idle", 5);

        // Single clean press, held long
        c = cyc;
        pif.btn_run = 1'b1;
        push(C_RUN, c + LAT);
        wait_cmd("run_press");
        chk("run_state_slow", 32'(pif.run_state), 32'd1);
        quiet("run_held", 100);
        pif.btn_run = 1'b0;
        quiet("run_release", 10);

        // Bounce on next, then stable high
        for (int k = 0; k < 2; k++) begin
            pif.btn_next = 1'b1;
            quiet("bounce", 2);
            pif.btn_next = 1'b0;
            quiet("bounce", 2);
        end
        c = cyc;
        pif.btn_next = 1'b1;
        push(C_NEXT, c + LAT);
        wait_cmd("next_bounce");
        chk("state_stepping", 32'(pif.run_state), 32'd3);
        quiet("next_held", 5);
        pif.btn_next = 1'b0;
        quiet("next_release", 10);

        // Step completion: count change exits STEPPING two edges later
        pif.count_in = 8'h06;
        tick();
        chk("step_exit_t1", 32'(pif.run_state), 32'd3);
        tick();
        chk("step_exit_t2", 32'(pif.run_state), 32'd0);

        // All four buttons at once
        c = cyc;
        pif.btn_next     = 1'b1;
        pif.btn_run      = 1'b1;
        pif.btn_speedrun = 1'b1;
        pif.btn_halt     = 1'b1;
        push(C_HALT, c + LAT);
        push(C_NEXT, c + LAT + 1);
        wait_cmd("simul_halt");
        wait_cmd("simul_next");
        chk("simul_state", 32'(pif.run_state), 32'd3);
        quiet("simul_no_runs", 20);
        pif.btn_next     = 1'b0;
        pif.btn_run      = 1'b0;
        pif.btn_speedrun = 1'b0;
        pif.btn_halt     = 1'b0;
        quiet("simul_release", 10);

        // Count change ignored in RUN_FAST
        c = cyc;
        pif.btn_speedrun = 1'b1;
        push(C_SPEED, c + LAT);
        wait_cmd("speed_press");
        chk("state_fast", 32'(pif.run_state), 32'd2);
        pif.count_in = 8'h07;
        quiet("fast_count", 3);
        chk("fast_keeps", 32'(pif.run_state), 32'd2);
        pif.btn_speedrun = 1'b0;
        quiet("speed_release", 10);

        // Command / count-change collision in STEPPING
        c = cyc;
        pif.btn_next = 1'b1;
        push(C_NEXT, c + LAT);
        wait_cmd("coll_next");
        pif.btn_next = 1'b0;
        quiet("coll_release", 10);
        chk("coll_stepping", 32'(pif.run_state), 32'd3);
        c = cyc;
        pif.btn_run = 1'b1;
        push(C_RUN, c + LAT);
        quiet("coll_wait", LAT - 2);
        pif.count_in = 8'h08;
        wait_cmd("coll_run");
        chk("coll_state", 32'(pif.run_state), 32'd1);
        pif.btn_run = 1'b0;
        quiet("coll_run_release", 10);

        // Reset mid-debounce restarts the debounce
        c = cyc;
        pif.btn_speedrun = 1'b1;
        quiet("rst_pre", 3);
        rst = 1'b1;
        tick();
        chk("rst_mid_pulses", 32'(pulses()), 32'd0);
        chk("rst_mid_state", 32'(pif.run_state), 32'd0);
        rst = 1'b0;
        c = cyc;
        push(C_SPEED, c + LAT);
        wait_cmd("rst_speed");
        chk("rst_speed_state", 32'(pif.run_state), 32'd2);
        pif.btn_speedrun = 1'b0;
        quiet("final", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/panel_ctrl.md
# panel_ctrl

Front-panel run-control generator for the model computer. It synchronises and debounces the four raw push-buttons (step, run, speed-run, halt) and turns each press into exactly one single-cycle command pulse. The pulses drive the program counter's NEXT, RUN, SPEEDRUN and ENABLE (halt) inputs. It also tracks the counter's run state from the commands it issued and from observed `count` changes, and exports that state for the panel LEDs.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised cycles required before a button level is accepted (20 ms at 50 MHz); legal range 1..2^20-1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_next`  in  1  raw step button, asynchronous, active-high.
- `btn_run`  in  1  raw run button, asynchronous, active-high.
- `btn_speedrun`  in  1  raw speed-run button, asynchronous, active-high.
- `btn_halt`  in  1  raw halt button, asynchronous, active-high.
- `count_in`  in  8  current program-counter value, fed back from the counter.
- `next_o`  out  1  one-cycle step command.
- `run_o`  out  1  one-cycle run (slow) command.
- `speedrun_o`  out  1  one-cycle run (fast) command.
- `halt_o`  out  1  one-cycle halt command.
- `run_state`  out  2  00 STOPPED, 01 RUN_SLOW, 10 RUN_FAST, 11 STEPPING.

## Operation

- **Synchroniser:** one 2-flop synchroniser per button (`s1` → `s2`).
- **Debouncer:** one per button, holding the accepted level `db` and a 20-bit counter `cnt`.
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A bounce resets the count. The counter never wraps.
- **Edge detect:** a rising edge of `db` (`db & ~db_d`) sets that button's pending bit. A falling edge of `db` does nothing. A held button yields exactly one command.
- **Arbiter:** at most one command pulse per cycle. Fixed priority: halt > next > run > speedrun.
  - The winning pending bit is cleared on the same edge its pulse register is set.
  - Losing pending bits persist and are issued on later cycles in priority order.
- **Halt cancels queued runs:** when halt is issued, pending run and speedrun are also cleared. Pending next is kept and follows on the next cycle.
- **Edge arriving on a pending bit:** a new edge on a button whose pending bit is already set is absorbed. There is no counting of presses.
- **Run-state FSM** (updates on the same edge the pulse register is set):
  - halt issued → STOPPED, from any state.
  - run issued → RUN_SLOW, from any state.
  - speedrun issued → RUN_FAST, from any state.
  - next issued → STEPPING, from any state. The counter finishes its current increment and stops.
  - In STEPPING, a change of `count_in` → STOPPED. Detection: `count_in != count_prev`, where `count_prev` is registered every cycle.
  - Count changes are ignored in all other states.
  - A command issued in the same cycle as a count change takes precedence over the count change.
- **Reset values:** all outputs 0 and `run_state` = STOPPED. All `s1`, `s2`, `db`, `db_d`, `cnt`, pending bits and `count_prev` are 0.
  - A button already held through reset is accepted after debounce and issues one command.

## Timing

- **Press latency:** a raw button going high and staying high before clock edge 0 gives a pulse register high after edge `DEBOUNCE_CYCLES+4`, with no arbitration contention. The breakdown is:
  - 2 edges for synchronisation;
  - `DEBOUNCE_CYCLES` edges for debounce;
  - 1 edge to set the pending bit;
  - 1 edge to set the pulse register.
- **Arbitration delay:** each higher-priority pending command ahead of a command delays it by one further cycle.
- **Pulse width:** all command outputs are registered and exactly 1 cycle wide. No two command outputs are ever high together.
- **STEPPING exit:** `run_state` leaves STEPPING 2 edges after `count_in` changes (1 edge to register `count_prev`, 1 edge to update state).
- **Reset mid-operation:** `rst` asserted on any edge forces the full reset state on that edge, including mid-debounce and with pending bits set. No command is emitted on that edge.

## Test plan

1. **Single clean press**, `DEBOUNCE_CYCLES=4`: `btn_run` high from cycle 0 → `run_o` high for exactly cycle 8 only, `run_state`=01 from cycle 8. Holding the button for 100 cycles gives no further pulse.
2. **Bounce rejection**, `DEBOUNCE_CYCLES=4`: `btn_next` toggles 1,0,1,0 every 2 cycles, then stays high → exactly one `next_o` pulse, 8 cycles after the final rise. No pulse is produced during the bouncing.
3. **Simultaneous press:** all four buttons rise in the same cycle → `halt_o` on cycle 8, then `next_o` on cycle 9. No `run_o` or `speedrun_o`. `run_state`=11 after cycle 9.
4. **Step completion:** in STEPPING, `count_in` goes 0x05→0x06 at cycle t → `run_state`=00 at t+2. In RUN_FAST, the same change leaves `run_state`=10.
5. **Reset mid-debounce:** `btn_speedrun` high, `rst` pulsed at cycle 4 → all outputs 0, and the debounce restarts. `speedrun_o` occurs at cycle 5+8=13 (the button must stay stable from the release of `rst`).
6. **Command/count collision:** in STEPPING, `count_in` changes in the same cycle `run_o` is issued → `run_state`=01, not 00.
